// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 window generator and its downstream stages.
// Holds the default geometry, counter-width helper and the tap-array type used
// by consumers built at the default pixel width.
package matrix_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_IMG_HDISP  = 640;
    localparam int unsigned DEF_IMG_VDISP  = 480;

    // Counters must be able to hold the terminal value (== limit), hence +1.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    localparam int unsigned COL_W = cnt_width(DEF_IMG_HDISP);
    localparam int unsigned ROW_W = cnt_width(DEF_IMG_VDISP);

    typedef logic [DEF_DATA_WIDTH-1:0] pix_t;
    // [row][col]; row 0 = line y-2, col 0 = x-2
    typedef pix_t tap_array_t [3][3];

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer, read-first, one word per column.
// Ports:
//   clk     - clock
//   wr_en   - write strobe, wr_addr/wr_data written on the clock edge
//   rd_en   - read strobe, rd_data registered on the clock edge
//   rd_data - holds its value while rd_en is low
// Contents are not reset so the array maps onto block RAM.
module line_buffer_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate process with non-blocking update: a same-address read returns old data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/matrix_gen_3x3.sv
// Streaming 3x3 window generator: raster pixel stream in, nine window taps out.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   per_frame_vsync/href/clken    - input raster syncs and pixel strobe
//   per_img_y                     - input pixel
//   matrix_frame_vsync/href       - syncs delayed two cycles
//   matrix_frame_clken            - one pulse per accepted pixel, two cycles later
//   matrix_p11..matrix_p33        - taps; row 1 = line y-2, column 1 = x-2
// Pipeline: stage 1 registers the pixel and reads the line buffer; stage 2
// updates the window and writes {pixel, line y-1} back to the same column.
module matrix_gen_3x3
    import matrix_pkg::*;
#(
    parameter int unsigned IMG_HDISP  = DEF_IMG_HDISP,
    parameter int unsigned IMG_VDISP  = DEF_IMG_VDISP,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_y,
    output logic                  matrix_frame_vsync,
    output logic                  matrix_frame_href,
    output logic                  matrix_frame_clken,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33
);

    localparam int unsigned COL_BITS = cnt_width(IMG_HDISP);
    localparam int unsigned ROW_BITS = cnt_width(IMG_VDISP);
    localparam int unsigned ADDR_W   = $clog2(IMG_HDISP);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(IMG_HDISP);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(IMG_VDISP);

    // Sync delay stages; stage 1 doubles as the edge-detect history.
    logic vs_d1_q, vs_d2_q, hr_d1_q, hr_d2_q;
    logic [COL_BITS-1:0] col_q, col_d, eff_col;
    logic [ROW_BITS-1:0] row_q, row_d, eff_row;
    logic armed_q, armed_d;
    logic vs_rise, href_fall, in_range, accept;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_pix_q;
    logic [COL_BITS-1:0]   s1_col_q;
    logic [ROW_BITS-1:0]   s1_row_q;

    logic                    clken_q;
    logic [DATA_WIDTH-1:0]   win_q [3][3];
    logic [DATA_WIDTH-1:0]   win_d [3][3];
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0]   line_y1, line_y2, y1_m, y2_m;

    assign vs_rise   = per_frame_vsync & ~vs_d1_q;
    assign href_fall = ~per_frame_href & hr_d1_q;

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        armed_d  = armed_q;
        eff_col  = col_q;
        eff_row  = row_q;
        in_range = (col_q < COL_MAX) && (row_q < ROW_MAX);
        // A pixel coinciding with the vsync edge is treated as (0,0).
        if (vs_rise) begin
            eff_col  = '0;
            eff_row  = '0;
            in_range = 1'b1;
            armed_d  = 1'b1;
        end
        accept = per_frame_clken & per_frame_href & armed_q & in_range;
        if (vs_rise) begin
            col_d = '0;
            row_d = '0;
        end else if (href_fall && (col_q != '0)) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? row_q : row_q + ROW_BITS'(1);
        end
        if (accept) begin
            col_d = eff_col + COL_BITS'(1);
        end
    end

    line_buffer_ram #(
        .DEPTH (IMG_HDISP),
        .WIDTH (2 * DATA_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (s1_valid_q),
        .wr_addr (s1_col_q[ADDR_W-1:0]),
        .wr_data ({s1_pix_q, line_y1}),
        .rd_en   (accept),
        .rd_addr (eff_col[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign line_y1 = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign line_y2 = rd_data[DATA_WIDTH-1:0];

    // Lines above the frame top read stale RAM, so they are masked to zero.
    assign y1_m = (s1_row_q == '0) ? '0 : line_y1;
    assign y2_m = (s1_row_q <= ROW_BITS'(1)) ? '0 : line_y2;

    always_comb begin
        win_d = win_q;
        if (s1_valid_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = (s1_col_q <= COL_BITS'(1)) ? '0 : win_q[r][1];
                win_d[r][1] = (s1_col_q == '0) ? '0 : win_q[r][2];
            end
            win_d[0][2] = y2_m;
            win_d[1][2] = y1_m;
            win_d[2][2] = s1_pix_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d1_q    <= 1'b0;
            vs_d2_q    <= 1'b0;
            hr_d1_q    <= 1'b0;
            hr_d2_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            armed_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            clken_q    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            vs_d1_q    <= per_frame_vsync;
            vs_d2_q    <= vs_d1_q;
            hr_d1_q    <= per_frame_href;
            hr_d2_q    <= hr_d1_q;
            col_q      <= col_d;
            row_q      <= row_d;
            armed_q    <= armed_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_pix_q <= per_img_y;
                s1_col_q <= eff_col;
                s1_row_q <= eff_row;
            end
            clken_q    <= s1_valid_q;
            win_q      <= win_d;
        end
    end

    assign matrix_frame_vsync = vs_d2_q;
    assign matrix_frame_href  = hr_d2_q;
    assign matrix_frame_clken = clken_q;
    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Scoreboard bench for matrix_gen_3x3 on a 4x3 frame.
module tb_matrix_gen_3x3;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, vsync, href, clken;
    logic [DW-1:0] pix;
    logic          m_vs, m_hr, m_ck;
    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    matrix_gen_3x3 #(
        .IMG_HDISP  (H),
        .IMG_VDISP  (V),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .per_frame_vsync    (vsync),
        .per_frame_href     (href),
        .per_frame_clken    (clken),
        .per_img_y          (pix),
        .matrix_frame_vsync (m_vs),
        .matrix_frame_href  (m_hr),
        .matrix_frame_clken (m_ck),
        .matrix_p11         (p11),
        .matrix_p12         (p12),
        .matrix_p13         (p13),
        .matrix_p21         (p21),
        .matrix_p22         (p22),
        .matrix_p23         (p23),
        .matrix_p31         (p31),
        .matrix_p32         (p32),
        .matrix_p33         (p33)
    );

    wire [9*DW-1:0] taps = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

    typedef struct {
        logic [9*DW-1:0] win;
        int              due;
    } exp_t;

    exp_t    sb[$];
    exp_t    e;
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    logic [1:0] rst_hist = 2'b00;
    logic [1:0] vs_hist  = 2'b00;
    logic [1:0] hr_hist  = 2'b00;
    logic [DW-1:0] cur_img [0:V-1][0:H-1];

    bit              hand_en = 1'b0;
    int              hand_x, hand_y;
    logic [9*DW-1:0] hand_win;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_hist <= {rst_hist[0], rst_n};
        vs_hist  <= {vs_hist[0], vsync};
        hr_hist  <= {hr_hist[0], href};
    end

    // Monitor: sync delay and every window strobe against the scoreboard.
    always @(negedge clk) begin
        if (rst_hist == 2'b11) begin
            checks++;
            if (m_vs !== vs_hist[1] || m_hr !== hr_hist[1]) begin
                errors++;
                $display("FAIL sync_delay: got vs=%b hr=%b expected vs=%b hr=%b (cycle %0d)",
                         m_vs, m_hr, vs_hist[1], hr_hist[1], cyc);
            end
        end
        if (m_ck !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got clken=%b taps=%h at cycle %0d, expected none",
                         m_ck, taps, cyc);
            end else begin
                e = sb.pop_front();
                if (taps !== e.win || cyc != e.due) begin
                    errors++;
                    $display("FAIL window: got taps=%h at cycle %0d expected taps=%h at cycle %0d",
                             taps, cyc, e.win, e.due);
                end
            end
        end
    end

    // Window defined directly from the frame image with zero padding.
    function automatic logic [9*DW-1:0] exp_win(input int x, input int y);
        logic [9*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int yy;
                int xx;
                yy = y - 2 + r;
                xx = x - 2 + c;
                if (yy >= 0 && xx >= 0) w[9*DW-1-DW*(3*r+c) -: DW] = cur_img[yy][xx];
            end
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clken = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_img(input logic [DW-1:0] base);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                cur_img[y][x] = base + DW'(16 * y + x);
            end
        end
    endtask

    task automatic pixel(input int x, input int y, input bit push);
        logic [9*DW-1:0] w;
        pix   = (x < H && y < V) ? cur_img[y][x] : 8'hEE;
        clken = 1'b1;
        if (push && x < H && y < V) begin
            w = (hand_en && x == hand_x && y == hand_y) ? hand_win : exp_win(x, y);
            sb.push_back('{win: w, due: cyc + 2});
        end
        tick();
        clken = 1'b0;
    endtask

    task automatic line(input int y, input bit push, input bit gaps, input int n);
        href = 1'b1;
        for (int x = 0; x < n; x++) begin
            if (gaps) idle(int'($urandom_range(3, 1)));
            pixel(x, y, push);
        end
        href  = 1'b0;
        clken = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic frame(input bit gaps, input int line0_len, input int extra_lines);
        frame_start();
        for (int y = 0; y < V; y++) line(y, 1'b1, gaps, (y == 0) ? line0_len : H);
        for (int i = 0; i < extra_lines; i++) line(V + i, 1'b1, gaps, H);
        idle(4);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({taps, m_ck, m_vs, m_hr} !== '0) begin
            errors++;
            $display("FAIL %s: got taps=%h clken=%b vs=%b hr=%b expected all zero",
                     name, taps, m_ck, m_vs, m_hr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        pix   = '0;
        repeat (3) tick();
        check_zero("reset_state");
        rst_n = 1'b1;
        tick();

        // Strobes before the first vsync are dropped.
        set_img(8'h40);
        line(0, 1'b0, 1'b0, H);
        idle(3);

        // Frame A: pixel = 16*row + col + 1, continuous.
        set_img(8'h01);
        hand_en  = 1'b1;
        hand_x   = 2;
        hand_y   = 2;
        hand_win = 72'h01_02_03_11_12_13_21_22_23;
        frame(1'b0, H, 0);

        // Frame B back-to-back: first pixel 0x55, 6-strobe first line, extra line.
        set_img(8'h80);
        cur_img[0][0] = 8'h55;
        hand_x   = 0;
        hand_y   = 0;
        hand_win = 72'h00_00_00_00_00_00_00_00_55;
        frame(1'b0, H + 2, 1);
        hand_en = 1'b0;

        // Frame A again with random clken gaps.
        set_img(8'h01);
        frame(1'b1, H, 0);

        // Reset mid-line with a pixel in stage 1.
        set_img(8'hA0);
        frame_start();
        line(0, 1'b1, 1'b0, H);
        href = 1'b1;
        pixel(0, 1, 1'b1);
        pixel(1, 1, 1'b1);
        pixel(2, 1, 1'b0);
        rst_n = 1'b0;
        clken = 1'b1;
        pix   = 8'hCC;
        tick();
        check_zero("reset_midline");
        rst_n = 1'b1;
        pixel(3, 1, 1'b0);
        href = 1'b0;
        tick();
        tick();
        line(2, 1'b0, 1'b0, H);
        idle(3);

        // Next frame after reset is fully correct.
        set_img(8'h31);
        frame(1'b1, H, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding windows expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
